alu_cmd_assembler: RTL

//  Upstream stage of the ALU command pipeline. Accepts a byte stream (valid/ready),

---
 rtl/alu_cmd_assembler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_assembler.sv
// Byte-stream framer for the ALU command pipeline: turns header+operand byte
// pairs into 10-bit commands {op,data2,data1}, buffered in a 2-entry output
// FIFO. Flags bad headers, operand timeouts and divide-by-zero commands.
module alu_cmd_assembler #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [9:0]       cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_div0,
    output logic             err_hdr,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, OPND} state_t;

    state_t           state, state_next;
    logic [1:0]       op;
    logic [TMR_W-1:0] timer;
    logic [1:0]       occ;
    logic [9:0]       tail_data;
    logic             tail_div0;

    logic       hdr_ok, hdr_bad, push, timeout_hit, pop;
    logic [9:0] push_data;
    logic       push_div0;

    assign push_data = {op, in_data};
    assign push_div0 = (op == 2'b11) && (in_data[7:4] == 4'd0);
    assign cmd_valid = (occ != 2'd0);
    assign pop       = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: header moves to OPND; operand or timeout returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hdr_ok) state_next = OPND;
            OPND:    if (push || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: ready and per-cycle accept/error strobes
    always_comb begin
        in_ready    = 1'b1;
        hdr_ok      = 1'b0;
        hdr_bad     = 1'b0;
        push        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_data[7:6] == 2'b10 && in_data[5:2] == 4'd0) hdr_ok = 1'b1;
                    else                                               hdr_bad = 1'b1;
                end
            end
            OPND: begin
                // Occupancy before any pop this cycle; no pop-through when full
                in_ready    = (occ != 2'd2);
                push        = in_valid && in_ready;
                timeout_hit = !push && (timer == TMR_LAST);
            end
            default: in_ready = 1'b1;
        endcase
    end

    // Latched opcode and inter-byte timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op    <= 2'b00;
            timer <= '0;
        end else if (hdr_ok) begin
            op    <= in_data[1:0];
            timer <= '0;
        end else if (state == OPND && !push) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Output buffer: head register drives the outputs, tail holds the second entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ       <= 2'd0;
            cmd_data  <= '0;
            cmd_div0  <= 1'b0;
            tail_data <= '0;
            tail_div0 <= 1'b0;
        end else begin
            case (occ)
                2'd0: if (push) begin
                    cmd_data <= push_data;
                    cmd_div0 <= push_div0;
                    occ      <= 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        cmd_data <= push_data;
                        cmd_div0 <= push_div0;
                    end else if (push) begin
                        tail_data <= push_data;
                        tail_div0 <= push_div0;
                        occ       <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: if (pop) begin
                    cmd_data <= tail_data;
                    cmd_div0 <= tail_div0;
                    if (push) begin
                        tail_data <= push_data;
                        tail_div0 <= push_div0;
                    end else begin
                        occ <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Error pulses and saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_hdr     <= 1'b0;
            err_timeout <= 1'b0;
            cmd_count   <= '0;
            drop_count  <= '0;
        end else begin
            err_hdr     <= hdr_bad;
            err_timeout <= timeout_hit;
            if (pop && cmd_count != '1)
                cmd_count <= cmd_count + CNT_W'(1);
            if ((hdr_bad || timeout_hit) && drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule
